johnson_counter_param: RTL and testbench

Parametrised successor to the team's fixed 4-bit Johnson (twisted-ring) counter built on the sync-reset-low flip-flop.
- Generalised to WIDTH stages.
- Adds enable, bidirectional stepping, synchronous parallel load, illegal-state detection with optional self-correction, a binary phase index and a terminal-count pulse.
- Used as a glitch-free multiphase sequencer and timing generator in the datapath control.

---
 rtl/johnson_counter_param_pkg.sv | 13 +
 rtl/johnson_phase_decode.sv | 48 ++++
 rtl/johnson_counter_param.sv | 83 ++++++++
 tb/tb_johnson_counter_param.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/johnson_counter_param_pkg.sv
// Shared constants for the parametrised Johnson counter and its phase decoder.
package johnson_counter_param_pkg;

    // Stepping direction encoding on the dir input.
    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    // Width of the binary phase index for a ring of the given number of stages.
    function automatic int phase_width(input int width);
        return $clog2(2 * width);
    endfunction

endpackage

// File: rtl/johnson_phase_decode.sv
// Combinational decoder: classifies a Johnson ring state as legal/illegal and
// converts legal states into a binary phase index 0..2*WIDTH-1.
module johnson_phase_decode
    import johnson_counter_param_pkg::*;
#(
    parameter int WIDTH = 4,
    localparam int PW = phase_width(WIDTH)
) (
    input  logic [WIDTH-1:0] out,
    output logic [PW-1:0]    phase,
    output logic             illegal
);

    int               ones_s;
    logic [WIDTH-1:0] lsb_run_s;
    logic [WIDTH-1:0] msb_run_s;
    logic             legal_s;

    // Popcount, the two reference run patterns with that many ones, and the phase formula.
    always_comb begin
        ones_s    = 0;
        lsb_run_s = '0;
        msb_run_s = '0;
        legal_s   = 1'b0;
        phase     = '0;
        illegal   = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            ones_s = ones_s + (out[i] ? 1 : 0);
        end
        // A legal code is exactly a run of k ones anchored at the LSB or at the MSB.
        for (int i = 0; i < WIDTH; i++) begin
            lsb_run_s[i] = (i < ones_s) ? 1'b1 : 1'b0;
            msb_run_s[i] = (i >= (WIDTH - ones_s)) ? 1'b1 : 1'b0;
        end
        legal_s = (out == lsb_run_s) || (out == msb_run_s);
        illegal = ~legal_s;
        if (!legal_s) begin
            phase = '0;
        end else if (out[0]) begin
            phase = PW'(ones_s);
        end else if (ones_s == 0) begin
            phase = '0;
        end else begin
            phase = PW'((2 * WIDTH) - ones_s);
        end
    end

endmodule

// File: rtl/johnson_counter_param.sv
// Parametrised Johnson (twisted-ring) counter with enable, direction, parallel
// load, illegal-state detection/self-correction, phase index and terminal count.
module johnson_counter_param
    import johnson_counter_param_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter bit SELF_CORRECT = 1'b1,
    localparam int PW = phase_width(WIDTH)
) (
    input  logic             clk,
    input  logic             sync_reset,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic [PW-1:0]    phase,
    output logic             illegal,
    output logic             tc
);

    localparam logic [PW-1:0] PHASE_LAST = PW'((2 * WIDTH) - 1);
    localparam logic [PW-1:0] PHASE_FIRST = PW'(0);

    logic [WIDTH-1:0] out_r;
    logic [WIDTH-1:0] step_s;
    logic [PW-1:0]    dec_phase_s;
    logic             dec_illegal_s;

    johnson_phase_decode #(
        .WIDTH(WIDTH)
    ) u_decode (
        .out    (out_r),
        .phase  (dec_phase_s),
        .illegal(dec_illegal_s)
    );

    // Next ring value for an enabled step; illegal codes are flushed to zero when self-correcting.
    always_comb begin
        step_s = out_r;
        if (dec_illegal_s && SELF_CORRECT) begin
            step_s = '0;
        end else if (dir == DIR_REV) begin
            step_s = {~out_r[0], out_r[WIDTH-1:1]};
        end else begin
            step_s = {out_r[WIDTH-2:0], ~out_r[WIDTH-1]};
        end
    end

    // State register with priority reset > load > enabled step > hold.
    always_ff @(posedge clk) begin
        if (!sync_reset) begin
            out_r <= '0;
        end else if (load) begin
            out_r <= load_val;
        end else if (en) begin
            out_r <= step_s;
        end else begin
            out_r <= out_r;
        end
    end

    // Decoded outputs are forced quiet while reset is held; tc flags the edge that will wrap.
    always_comb begin
        phase   = '0;
        illegal = 1'b0;
        tc      = 1'b0;
        if (sync_reset) begin
            phase   = dec_phase_s;
            illegal = dec_illegal_s;
            tc      = en & ~load & ~dec_illegal_s &
                      (((dir == DIR_FWD) && (dec_phase_s == PHASE_LAST)) ||
                       ((dir == DIR_REV) && (dec_phase_s == PHASE_FIRST)));
        end else begin
            phase   = '0;
            illegal = 1'b0;
            tc      = 1'b0;
        end
    end

    assign out = out_r;

endmodule

// File: tb/tb_johnson_counter_param.sv
// Self-checking bench: two WIDTH=4 counters (self-correcting and not) sharing
// stimulus, plus one WIDTH=8 counter, compared against a phase-table model.
module tb_johnson_counter_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst4, load4, en4, dir4;
    logic [3:0] lv4;
    logic [3:0] out_a, out_b;
    logic [2:0] phase_a, phase_b;
    logic       ill_a, ill_b, tc_a, tc_b;

    logic       rst8, load8, en8, dir8;
    logic [7:0] lv8, out8;
    logic [3:0] phase8;
    logic       ill8, tc8;

    int ma = 0, mb = 0, m8 = 0;
    int checks = 0, passes = 0;

    johnson_counter_param #(.WIDTH(4), .SELF_CORRECT(1'b1)) dut_a (
        .clk(clk), .sync_reset(rst4), .en(en4), .dir(dir4), .load(load4), .load_val(lv4),
        .out(out_a), .phase(phase_a), .illegal(ill_a), .tc(tc_a));

    johnson_counter_param #(.WIDTH(4), .SELF_CORRECT(1'b0)) dut_b (
        .clk(clk), .sync_reset(rst4), .en(en4), .dir(dir4), .load(load4), .load_val(lv4),
        .out(out_b), .phase(phase_b), .illegal(ill_b), .tc(tc_b));

    johnson_counter_param #(.WIDTH(8), .SELF_CORRECT(1'b1)) dut_8 (
        .clk(clk), .sync_reset(rst8), .en(en8), .dir(dir8), .load(load8), .load_val(lv8),
        .out(out8), .phase(phase8), .illegal(ill8), .tc(tc8));

    // ---------------- reference model ----------------
    // Code for phase p: p ones at the LSB for p<=w, else 2w-p ones at the MSB.
    function automatic int code_of(input int w, input int p);
        if (p <= w) return (1 << p) - 1;
        return ((1 << w) - 1) ^ ((1 << (p - w)) - 1);
    endfunction

    function automatic int phase_of(input int w, input int v);
        for (int p = 0; p < 2 * w; p++) if (code_of(w, p) == v) return p;
        return -1;
    endfunction

    function automatic int model_next(input int w, input bit sc, input int v, input bit r,
                                      input bit ld, input int lv, input bit e, input bit d);
        int p, full;
        full = 1 << w;
        if (!r) return 0;
        if (ld) return lv;
        if (!e) return v;
        p = phase_of(w, v);
        if (p >= 0) return code_of(w, d ? (p + 2 * w - 1) % (2 * w) : (p + 1) % (2 * w));
        if (sc) return 0;
        if (!d) return ((v * 2) % full) + ((v >= full / 2) ? 0 : 1);
        return (v / 2) + (((v % 2) == 1) ? 0 : full / 2);
    endfunction

    function automatic int exp_phase(input int w, input int v, input bit r);
        int p;
        p = phase_of(w, v);
        if (!r || p < 0) return 0;
        return p;
    endfunction

    function automatic bit exp_ill(input int w, input int v, input bit r);
        return r && (phase_of(w, v) < 0);
    endfunction

    function automatic bit exp_tc(input int w, input int v, input bit r, input bit ld,
                                  input bit e, input bit d);
        int p;
        p = phase_of(w, v);
        if (!r || ld || !e || p < 0) return 1'b0;
        return d ? (p == 0) : (p == 2 * w - 1);
    endfunction

    // ---------------- drivers ----------------
    task automatic drive4(input bit r, input bit ld, input int lv, input bit e, input bit d);
        @(negedge clk);
        rst4 = r; load4 = ld; lv4 = 4'(lv); en4 = e; dir4 = d;
        #1;
    endtask

    task automatic drive8(input bit r, input bit ld, input int lv, input bit e, input bit d);
        @(negedge clk);
        rst8 = r; load8 = ld; lv8 = 8'(lv); en8 = e; dir8 = d;
        #1;
    endtask

    // Clock edge: advance all three models with the inputs the DUTs sample.
    task automatic tick;
        @(posedge clk);
        ma = model_next(4, 1'b1, ma, rst4, load4, int'(lv4), en4, dir4);
        mb = model_next(4, 1'b0, mb, rst4, load4, int'(lv4), en4, dir4);
        m8 = model_next(8, 1'b1, m8, rst8, load8, int'(lv8), en8, dir8);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        for (int i = 0; i < 2; i++) begin
            drive4(1'b0, 1'(i), 15, 1'b1, 1'b0);
            checks++; if (phase_a !== 3'd0) $display("FAIL reset_phase got %0d want 0", phase_a); else passes++;
            checks++; if (ill_a !== 1'b0 || tc_a !== 1'b0) $display("FAIL reset_ill_tc got %b%b want 00", ill_a, tc_a); else passes++;
            tick;
        end
        checks++; if (out_a !== 4'd0 || out_b !== 4'd0) $display("FAIL reset_out got %b/%b want 0000", out_a, out_b); else passes++;
        checks++; if (out8 !== 8'd0) $display("FAIL reset_out8 got %b want 0", out8); else passes++;
    endtask

    task automatic test_forward;
        int seq [0:8];
        seq = '{0, 1, 3, 7, 15, 14, 12, 8, 0};
        for (int i = 0; i < 9; i++) begin
            drive4(1'b1, 1'b0, 0, 1'b1, 1'b0);
            checks++; if (out_a !== 4'(seq[i])) $display("FAIL fwd_out step %0d got %b want %b", i, out_a, 4'(seq[i])); else passes++;
            checks++; if (phase_a !== 3'(i % 8)) $display("FAIL fwd_phase step %0d got %0d want %0d", i, phase_a, i % 8); else passes++;
            checks++; if (tc_a !== (i == 7)) $display("FAIL fwd_tc step %0d got %b want %b", i, tc_a, (i == 7)); else passes++;
            tick;
        end
    endtask

    task automatic test_reverse;
        int seq [0:3];
        seq = '{3, 1, 0, 8};
        // State is 0001; two more forward steps reach 0111.
        for (int i = 0; i < 2; i++) begin drive4(1'b1, 1'b0, 0, 1'b1, 1'b0); tick; end
        drive4(1'b1, 1'b0, 0, 1'b1, 1'b1);
        checks++; if (out_a !== 4'b0111 || phase_a !== 3'd3) $display("FAIL rev_start got %b/%0d want 0111/3", out_a, phase_a); else passes++;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) drive4(1'b1, 1'b0, 0, 1'b1, 1'b1);
            checks++; if (tc_a !== (out_a == 4'd0)) $display("FAIL rev_tc step %0d got %b want %b", i, tc_a, (out_a == 4'd0)); else passes++;
            tick;
            checks++; if (out_a !== 4'(seq[i])) $display("FAIL rev_out step %0d got %b want %b", i, out_a, 4'(seq[i])); else passes++;
        end
    endtask

    task automatic test_load_hold;
        // At 1000 with forward enable tc would fire, but load must suppress it.
        drive4(1'b1, 1'b1, 12, 1'b1, 1'b0);
        checks++; if (tc_a !== 1'b0) $display("FAIL load_tc got %b want 0", tc_a); else passes++;
        tick;
        checks++; if (out_a !== 4'b1100 || phase_a !== 3'd6) $display("FAIL load_out got %b/%0d want 1100/6", out_a, phase_a); else passes++;
        for (int i = 0; i < 3; i++) begin
            drive4(1'b1, 1'b0, int'($urandom_range(0, 15)), 1'b0, 1'($urandom_range(0, 1)));
            tick;
            checks++; if (out_a !== 4'b1100) $display("FAIL hold_out cycle %0d got %b want 1100", i, out_a); else passes++;
        end
    endtask

    task automatic test_illegal;
        drive4(1'b1, 1'b1, 5, 1'b0, 1'b0);
        tick;
        drive4(1'b1, 1'b0, 0, 1'b1, 1'b0);
        checks++; if (ill_a !== 1'b1 || ill_b !== 1'b1) $display("FAIL ill_flag got %b/%b want 1/1", ill_a, ill_b); else passes++;
        checks++; if (phase_a !== 3'd0 || tc_a !== 1'b0) $display("FAIL ill_phase_tc got %0d/%b want 0/0", phase_a, tc_a); else passes++;
        tick;
        checks++; if (out_a !== 4'b0000 || ill_a !== 1'b0) $display("FAIL ill_correct got %b/%b want 0000/0", out_a, ill_a); else passes++;
        checks++; if (out_b !== 4'b1011 || ill_b !== 1'b1) $display("FAIL ill_shift got %b/%b want 1011/1", out_b, ill_b); else passes++;
        drive4(1'b1, 1'b0, 0, 1'b0, 1'b0);
        tick;
        checks++; if (out_b !== 4'b1011 || ill_b !== 1'b1) $display("FAIL ill_hold got %b/%b want 1011/1", out_b, ill_b); else passes++;
        drive4(1'b1, 1'b1, 6, 1'b0, 1'b0);
        tick;
        drive4(1'b1, 1'b0, 0, 1'b1, 1'b1);
        tick;
        checks++; if (out_a !== 4'b0000 || out_b !== 4'b1011) $display("FAIL ill_rev got %b/%b want 0000/1011", out_a, out_b); else passes++;
    endtask

    task automatic test_width8;
        int pulses;
        drive8(1'b0, 1'b0, 0, 1'b0, 1'b0);
        tick;
        for (int i = 0; i < 9; i++) begin drive8(1'b1, 1'b0, 0, 1'b1, 1'b0); tick; end
        drive8(1'b0, 1'b1, 255, 1'b1, 1'b0);
        checks++; if (tc8 !== 1'b0 || phase8 !== 4'd0) $display("FAIL w8_rst_comb got %b/%0d want 0/0", tc8, phase8); else passes++;
        tick;
        checks++; if (out8 !== 8'd0) $display("FAIL w8_rst_out got %b want 0", out8); else passes++;
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            drive8(1'b1, 1'b0, 0, 1'b1, 1'b0);
            if (tc8 === 1'b1) pulses++;
            tick;
        end
        checks++; if (pulses != 1 || out8 !== 8'd0) $display("FAIL w8_run got %0d pulses out %b want 1 pulse out 0", pulses, out8); else passes++;
    endtask

    task automatic test_random;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            rst4  = ($urandom_range(0, 19) != 0);
            load4 = ($urandom_range(0, 7) == 0);
            lv4   = ($urandom_range(0, 1) == 1) ? 4'(code_of(4, int'($urandom_range(0, 7)))) : 4'($urandom);
            en4   = ($urandom_range(0, 3) != 0);
            dir4  = 1'($urandom_range(0, 1));
            rst8  = ($urandom_range(0, 19) != 0);
            load8 = ($urandom_range(0, 7) == 0);
            lv8   = 8'($urandom);
            en8   = ($urandom_range(0, 3) != 0);
            dir8  = 1'($urandom_range(0, 1));
            #1;
            checks++; if (phase_a !== 3'(exp_phase(4, ma, rst4)) || ill_a !== exp_ill(4, ma, rst4) || tc_a !== exp_tc(4, ma, rst4, load4, en4, dir4))
                $display("FAIL rnd_comb_a cyc %0d got %0d/%b/%b want %0d/%b/%b", i, phase_a, ill_a, tc_a, exp_phase(4, ma, rst4), exp_ill(4, ma, rst4), exp_tc(4, ma, rst4, load4, en4, dir4)); else passes++;
            checks++; if (phase_b !== 3'(exp_phase(4, mb, rst4)) || ill_b !== exp_ill(4, mb, rst4) || tc_b !== exp_tc(4, mb, rst4, load4, en4, dir4))
                $display("FAIL rnd_comb_b cyc %0d got %0d/%b/%b want %0d/%b/%b", i, phase_b, ill_b, tc_b, exp_phase(4, mb, rst4), exp_ill(4, mb, rst4), exp_tc(4, mb, rst4, load4, en4, dir4)); else passes++;
            checks++; if (phase8 !== 4'(exp_phase(8, m8, rst8)) || ill8 !== exp_ill(8, m8, rst8) || tc8 !== exp_tc(8, m8, rst8, load8, en8, dir8))
                $display("FAIL rnd_comb_8 cyc %0d got %0d/%b/%b want %0d/%b/%b", i, phase8, ill8, tc8, exp_phase(8, m8, rst8), exp_ill(8, m8, rst8), exp_tc(8, m8, rst8, load8, en8, dir8)); else passes++;
            tick;
            checks++; if (out_a !== 4'(ma) || out_b !== 4'(mb)) $display("FAIL rnd_out4 cyc %0d got %b/%b want %b/%b", i, out_a, out_b, 4'(ma), 4'(mb)); else passes++;
            checks++; if (out8 !== 8'(m8)) $display("FAIL rnd_out8 cyc %0d got %b want %b", i, out8, 8'(m8)); else passes++;
        end
    endtask

    initial begin
        rst4 = 1'b0; load4 = 1'b0; lv4 = 4'd0; en4 = 1'b0; dir4 = 1'b0;
        rst8 = 1'b0; load8 = 1'b0; lv8 = 8'd0; en8 = 1'b0; dir8 = 1'b0;
        test_reset;
        test_forward;
        test_reverse;
        test_load_hold;
        test_illegal;
        test_width8;
        test_random;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
